// File: rtl/core_debug_sequencer_if.sv
// Host link between the board-level bridge and core_debug_sequencer.
// The master side is the host; the slave side is the sequencer.
interface core_debug_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        abort;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata, abort, resp_ready,
    input  cmd_ready, resp_valid, resp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, abort, resp_ready,
    output cmd_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/core_debug_sequencer.sv
// Serializes host debug commands into cache debug writes/reads and bounded
// run windows, keeping the core in reset outside of RUN.
module core_debug_sequencer #(
  parameter int RUN_CNT_W = 32,
  parameter int DRD_LAT   = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  core_debug_sequencer_if.slave       host,
  output logic                        core_rst,
  output logic [31:0]                 icache_a2,
  output logic [31:0]                 icache_wd2,
  output logic [3:0]                  icache_we2,
  output logic [31:0]                 dcache_a2,
  output logic [31:0]                 dcache_wd2,
  output logic [3:0]                  dcache_we2,
  input  logic [31:0]                 dcache_rd2
);

  // state   | meaning
  // IDLE    | waiting for a host command, cmd_ready high
  // WR_I    | single icache debug write cycle
  // WR_D    | single dcache debug write cycle
  // RD_WAIT | dcache address held, counting read latency
  // RUN     | core out of reset, counting cycles (held in reset if count=0)
  // RESP    | response presented until host accepts
  typedef enum logic [2:0] {
    S_IDLE, S_WR_I, S_WR_D, S_RD_WAIT, S_RUN, S_RESP
  } state_t;

  localparam logic [1:0] OP_WR_INST = 2'd0;
  localparam logic [1:0] OP_WR_DATA = 2'd1;
  localparam logic [1:0] OP_RD_DATA = 2'd2;
  localparam logic [1:0] OP_RUN     = 2'd3;
  localparam logic [2:0] LAT_INIT   = 3'(DRD_LAT - 1);

  state_t                 state_q, state_d;
  logic                   core_rst_q, core_rst_d;
  logic                   cmd_ready_q, cmd_ready_d;
  logic                   resp_valid_q, resp_valid_d;
  logic [31:0]            resp_data_q, resp_data_d;
  logic [31:0]            icache_a2_q, icache_a2_d;
  logic [31:0]            icache_wd2_q, icache_wd2_d;
  logic [3:0]             icache_we2_q, icache_we2_d;
  logic [31:0]            dcache_a2_q, dcache_a2_d;
  logic [31:0]            dcache_wd2_q, dcache_wd2_d;
  logic [3:0]             dcache_we2_q, dcache_we2_d;
  logic [RUN_CNT_W-1:0]   run_cnt_q, run_cnt_d;
  logic [RUN_CNT_W-1:0]   run_len_q, run_len_d;
  logic [2:0]             lat_cnt_q, lat_cnt_d;
  logic [RUN_CNT_W-1:0]   run_cnt_inc;
  logic [31:0]            addr_aligned;
  logic [RUN_CNT_W-1:0]   cmd_run_len;

  assign addr_aligned = host.cmd_addr & 32'hFFFF_FFFC;
  assign cmd_run_len  = host.cmd_wdata[RUN_CNT_W-1:0];
  assign run_cnt_inc  = run_cnt_q + RUN_CNT_W'(1);

  always_comb begin
    state_d      = state_q;
    core_rst_d   = core_rst_q;
    resp_data_d  = resp_data_q;
    icache_a2_d  = icache_a2_q;
    icache_wd2_d = icache_wd2_q;
    icache_we2_d = 4'h0;
    dcache_a2_d  = dcache_a2_q;
    dcache_wd2_d = dcache_wd2_q;
    dcache_we2_d = 4'h0;
    run_cnt_d    = run_cnt_q;
    run_len_d    = run_len_q;
    lat_cnt_d    = lat_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (host.cmd_valid && cmd_ready_q) begin
          case (host.cmd_op)
            OP_WR_INST: begin
              state_d      = S_WR_I;
              icache_a2_d  = addr_aligned;
              icache_wd2_d = host.cmd_wdata;
              icache_we2_d = 4'hF;
            end
            OP_WR_DATA: begin
              state_d      = S_WR_D;
              dcache_a2_d  = addr_aligned;
              dcache_wd2_d = host.cmd_wdata;
              dcache_we2_d = 4'hF;
            end
            OP_RD_DATA: begin
              state_d     = S_RD_WAIT;
              dcache_a2_d = addr_aligned;
              lat_cnt_d   = LAT_INIT;
            end
            OP_RUN: begin
              state_d    = S_RUN;
              run_len_d  = cmd_run_len;
              run_cnt_d  = '0;
              // a zero-length run never releases the core
              core_rst_d = (cmd_run_len == '0);
            end
          endcase
        end
      end
      S_WR_I, S_WR_D: begin
        state_d     = S_RESP;
        resp_data_d = 32'h0;
      end
      S_RD_WAIT: begin
        if (lat_cnt_q == 3'd0) begin
          state_d     = S_RESP;
          resp_data_d = dcache_rd2;
        end else begin
          lat_cnt_d = lat_cnt_q - 3'd1;
        end
      end
      S_RUN: begin
        if (core_rst_q) begin
          state_d     = S_RESP;
          resp_data_d = 32'h0;
        end else begin
          run_cnt_d = run_cnt_inc;
          // the current low cycle counts whether we stop on length or abort
          if (run_cnt_inc == run_len_q || host.abort) begin
            state_d     = S_RESP;
            core_rst_d  = 1'b1;
            resp_data_d = 32'(run_cnt_inc);
          end
        end
      end
      S_RESP: begin
        if (host.resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    cmd_ready_d  = (state_d == S_IDLE);
    resp_valid_d = (state_d == S_RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      core_rst_q   <= 1'b1;
      cmd_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 32'h0;
      icache_a2_q  <= 32'h0;
      icache_wd2_q <= 32'h0;
      icache_we2_q <= 4'h0;
      dcache_a2_q  <= 32'h0;
      dcache_wd2_q <= 32'h0;
      dcache_we2_q <= 4'h0;
      run_cnt_q    <= '0;
      run_len_q    <= '0;
      lat_cnt_q    <= 3'd0;
    end else begin
      state_q      <= state_d;
      core_rst_q   <= core_rst_d;
      cmd_ready_q  <= cmd_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      icache_a2_q  <= icache_a2_d;
      icache_wd2_q <= icache_wd2_d;
      icache_we2_q <= icache_we2_d;
      dcache_a2_q  <= dcache_a2_d;
      dcache_wd2_q <= dcache_wd2_d;
      dcache_we2_q <= dcache_we2_d;
      run_cnt_q    <= run_cnt_d;
      run_len_q    <= run_len_d;
      lat_cnt_q    <= lat_cnt_d;
    end
  end

  assign host.cmd_ready  = cmd_ready_q;
  assign host.resp_valid = resp_valid_q;
  assign host.resp_data  = resp_data_q;
  assign core_rst        = core_rst_q;
  assign icache_a2       = icache_a2_q;
  assign icache_wd2      = icache_wd2_q;
  assign icache_we2      = icache_we2_q;
  assign dcache_a2       = dcache_a2_q;
  assign dcache_wd2      = dcache_wd2_q;
  assign dcache_we2      = dcache_we2_q;

endmodule

// File: tb/tb_core_debug_sequencer.sv
// Randomized bench for core_debug_sequencer against a command-level model
// of expected responses, write pulses and run lengths.
module tb_core_debug_sequencer;
  localparam int DRD_LAT = 1;
  localparam int BUDGET  = 300;
  localparam logic [1:0] OP_WI = 2'd0, OP_WD = 2'd1, OP_RD = 2'd2, OP_RUN = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        core_rst;
  logic [31:0] icache_a2, icache_wd2, dcache_a2, dcache_wd2, dcache_rd2;
  logic [3:0]  icache_we2, dcache_we2;

  logic [31:0] dut_dmem   [16] = '{default: 32'h0};
  logic [31:0] dmem_model [16] = '{default: 32'h0};

  int n_vec = 0;
  int n_err = 0;

  core_debug_sequencer_if host_if ();

  core_debug_sequencer #(.RUN_CNT_W(32), .DRD_LAT(DRD_LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .host       (host_if.slave),
    .core_rst   (core_rst),
    .icache_a2  (icache_a2),
    .icache_wd2 (icache_wd2),
    .icache_we2 (icache_we2),
    .dcache_a2  (dcache_a2),
    .dcache_wd2 (dcache_wd2),
    .dcache_we2 (dcache_we2),
    .dcache_rd2 (dcache_rd2)
  );

  always #5 clk = ~clk;

  // data cache stand-in: accepts the sequencer's debug writes, reads combinationally
  always @(posedge clk) if (dcache_we2 == 4'hF) dut_dmem[dcache_a2[5:2]] <= dcache_wd2;
  assign dcache_rd2 = dut_dmem[dcache_a2[5:2]];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input int abort_at, input int rdy_dly);
    int exp_r, exp_low, exp_ip, exp_dp;
    int lows, ip, dp, r;
    logic [31:0] exp_data;
    exp_r = 2; exp_low = 0; exp_ip = 0; exp_dp = 0; exp_data = 32'h0;
    lows = 0; ip = 0; dp = 0; r = 0;
    case (op)
      OP_WI: exp_ip = 1;
      OP_WD: begin exp_dp = 1; dmem_model[addr[5:2]] = wdata; end
      OP_RD: begin exp_r = 1 + DRD_LAT; exp_data = dmem_model[addr[5:2]]; end
      default: begin
        if (wdata != 0) begin
          exp_low  = (abort_at >= 1 && abort_at < int'(wdata)) ? abort_at : int'(wdata);
          exp_r    = exp_low + 1;
          exp_data = 32'(exp_low);
        end
      end
    endcase

    host_if.cmd_valid = 1'b1;
    host_if.cmd_op    = op;
    host_if.cmd_addr  = addr;
    host_if.cmd_wdata = wdata;
    chk("cmd_ready_idle", {31'b0, host_if.cmd_ready}, 32'd1);
    @(posedge clk);
    for (int i = 1; i <= BUDGET; i++) begin
      @(negedge clk);
      host_if.cmd_valid = 1'b0;
      if (icache_we2 != 4'h0) begin
        ip++;
        chk("icache_we2", {28'b0, icache_we2}, 32'hF);
        chk("icache_a2", icache_a2, addr & 32'hFFFF_FFFC);
        chk("icache_wd2", icache_wd2, wdata);
      end
      if (dcache_we2 != 4'h0) begin
        dp++;
        chk("dcache_we2", {28'b0, dcache_we2}, 32'hF);
        chk("dcache_a2", dcache_a2, addr & 32'hFFFF_FFFC);
      end
      if (!core_rst) lows++;
      if (host_if.resp_valid) begin r = i; break; end
      chk("cmd_ready_busy", {31'b0, host_if.cmd_ready}, 32'd0);
      host_if.abort = (op == OP_RUN) ? (i == abort_at) : ($urandom_range(0, 1) == 1);
    end
    host_if.abort = 1'b0;
    if (r == 0) begin
      chk("resp_timeout", 32'd0, 32'd1);
      return;
    end
    chk("resp_latency", 32'(r), 32'(exp_r));
    chk("resp_data", host_if.resp_data, exp_data);
    chk("low_cycles", 32'(lows), 32'(exp_low));
    chk("ic_pulses", 32'(ip), 32'(exp_ip));
    chk("dc_pulses", 32'(dp), 32'(exp_dp));
    for (int k = 0; k < rdy_dly; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("resp_hold_valid", {31'b0, host_if.resp_valid}, 32'd1);
      chk("resp_hold_data", host_if.resp_data, exp_data);
      chk("cmd_ready_resp", {31'b0, host_if.cmd_ready}, 32'd0);
    end
    host_if.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    host_if.resp_ready = 1'b0;
    chk("resp_done", {31'b0, host_if.resp_valid}, 32'd0);
    chk("cmd_ready_back", {31'b0, host_if.cmd_ready}, 32'd1);
    chk("core_rst_idle", {31'b0, core_rst}, 32'd1);
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] wd;
    host_if.cmd_valid  = 1'b0;
    host_if.cmd_op     = 2'd0;
    host_if.cmd_addr   = 32'h0;
    host_if.cmd_wdata  = 32'h0;
    host_if.abort      = 1'b0;
    host_if.resp_ready = 1'b0;
    #12;
    chk("rst_core_rst", {31'b0, core_rst}, 32'd1);
    chk("rst_cmd_ready", {31'b0, host_if.cmd_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, host_if.resp_valid}, 32'd0);
    chk("rst_resp_data", host_if.resp_data, 32'h0);
    chk("rst_we2", {24'b0, icache_we2, dcache_we2}, 32'h0);
    chk("rst_a2", icache_a2 | dcache_a2 | icache_wd2 | dcache_wd2, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    do_cmd(OP_WI, 32'h0000_0007, 32'h0050_0093, 0, 0);
    do_cmd(OP_WD, 32'h0000_0010, 32'hDEAD_BEEF, 0, 1);
    do_cmd(OP_RD, 32'h0000_0010, 32'h0, 0, 0);
    do_cmd(OP_RUN, 32'h0, 32'd5, 0, 0);
    do_cmd(OP_RUN, 32'h0, 32'd0, 1, 0);
    do_cmd(OP_RUN, 32'h0, 32'd100, 10, 4);
    do_cmd(OP_RUN, 32'h0, 32'd7, 7, 0);

    for (int n = 0; n < 60; n++) begin
      op = 2'($urandom_range(0, 3));
      wd = (op == OP_RUN) ? 32'($urandom_range(0, 20)) : $urandom;
      do_cmd(op, 32'($urandom_range(0, 63)), wd,
             ($urandom_range(0, 2) == 0) ? $urandom_range(1, 22) : 0,
             $urandom_range(0, 3));
    end

    // asynchronous reset in the middle of a run window
    host_if.cmd_valid = 1'b1;
    host_if.cmd_op    = OP_RUN;
    host_if.cmd_wdata = 32'd50;
    @(posedge clk);
    @(negedge clk);
    host_if.cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("run_core_rst_low", {31'b0, core_rst}, 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("arst_core_rst", {31'b0, core_rst}, 32'd1);
    chk("arst_cmd_ready", {31'b0, host_if.cmd_ready}, 32'd1);
    chk("arst_resp_valid", {31'b0, host_if.resp_valid}, 32'd0);
    chk("arst_we2", {24'b0, icache_we2, dcache_we2}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_resp_valid", {31'b0, host_if.resp_valid}, 32'd0);
    do_cmd(OP_RUN, 32'h0, 32'd3, 0, 0);
    do_cmd(OP_RD, 32'h0000_0010, 32'h0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
